// File: rtl/aes256_encipher_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes256_encipher_seq
// Description : Iterative AES-256 encipher, one round per clock, key schedule
//               expanded on the fly from a 256-bit sliding key window.
//               Optional macro AES256_ENC_BACK2BACK_EN lets a new job be
//               accepted on the same edge as the output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module aes256_encipher_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] datain,
    input  logic [255:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dataout,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_ROUND = 4'd14;

    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       fsm_q;
    logic [3:0]   round_q;
    logic [127:0] blk_q;
    logic [255:0] kwin_q;
    logic [127:0] dout_q;

    logic [127:0] blk_d;
    logic [255:0] kwin_d;
    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [31:0]  w_temp;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [7:0]   w_rcon;
    logic         w_accept;

    // Entry 0 sits in the top byte, so the bit offset of entry x is 8*(255-x).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] base;
        base = {~x, 3'b000};
        return c_SBOX[base +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte i of the state is row i%4, column i/4; byte 0 is the top byte.
    always_comb begin
        w_sub   = '0;
        w_shift = '0;
        w_mix   = '0;
        for (int i = 0; i < 16; i++) begin
            w_sub[127-8*i -: 8] = sbox(blk_q[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[127-8*(r+4*c) -: 8] = w_sub[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mix[127-32*c -: 32] = mixcol(w_shift[127-32*c -: 32]);
        end
        blk_d = ((round_q == c_LAST_ROUND) ? w_shift : w_mix) ^ kwin_q[127:0];
    end

    // Window holds {older half, current half}; odd rounds produce the next
    // half with RotWord+Rcon, even rounds with SubWord only.
    always_comb begin
        w_rcon = 8'h01 << round_q[3:1];
        if (round_q[0]) begin
            w_temp = subword({kwin_q[23:0], kwin_q[31:24]}) ^ {w_rcon, 24'h000000};
        end else begin
            w_temp = subword(kwin_q[31:0]);
        end
        w_n0   = kwin_q[255:224] ^ w_temp;
        w_n1   = kwin_q[223:192] ^ w_n0;
        w_n2   = kwin_q[191:160] ^ w_n1;
        w_n3   = kwin_q[159:128] ^ w_n2;
        kwin_d = {kwin_q[127:0], w_n0, w_n1, w_n2, w_n3};
    end

`ifdef AES256_ENC_BACK2BACK_EN
    assign in_ready = !rst && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));
`else
    assign in_ready = !rst && (fsm_q == IDLE);
`endif

    assign w_accept  = in_valid && in_ready;
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == ROUND);
    assign dataout   = dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            blk_q   <= '0;
            kwin_q  <= '0;
            dout_q  <= '0;
        end else if (w_accept) begin
            blk_q   <= datain ^ key[255:128];
            kwin_q  <= key;
            round_q <= 4'd1;
            fsm_q   <= ROUND;
        end else begin
            case (fsm_q)
                IDLE: begin
                    fsm_q <= IDLE;
                end
                ROUND: begin
                    blk_q   <= blk_d;
                    kwin_q  <= kwin_d;
                    round_q <= round_q + 4'd1;
                    if (round_q == c_LAST_ROUND) begin
                        dout_q <= blk_d;
                        fsm_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q <= IDLE;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes256_encipher_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes256_encipher_seq
// Description : Self-checking bench for aes256_encipher_seq against a
//               byte-level FIPS-197 cipher/inverse-cipher model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes256_encipher_seq;

    localparam logic [127:0] C3_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C3_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] ZERO_CT = 128'hdc95c078a2408989ad48a21492842087;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] datain;
    logic [255:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dataout;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    aes256_encipher_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            end
            s = s ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] k, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        for (int i = 0; i < 16; i++) begin
            s[127-8*i -: 8] = inv ? isb[s[127-8*i -: 8]] : sb[s[127-8*i -: 8]];
        end
        return s;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
                else     o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [7:0]   cf [4];
        logic [7:0]   v;
        logic [127:0] o;
        o = '0;
        if (inv) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                v = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    v = v ^ gmul(cf[(j-r+4)%4], s[127-8*(4*c+j) -: 8]);
                end
                o[127-8*(4*c+r) -: 8] = v;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [255:0] k);
        logic [127:0] s;
        s = pt ^ round_key(k, 0);
        for (int r = 1; r <= 14; r++) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r < 14) s = mix_cols(s, 1'b0);
            s = s ^ round_key(k, r);
        end
        return s;
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [255:0] k);
        logic [127:0] s;
        s = ct ^ round_key(k, 14);
        for (int r = 13; r >= 0; r--) begin
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ round_key(k, r);
            if (r > 0) s = mix_cols(s, 1'b1);
        end
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_job(input logic [127:0] pt, input logic [255:0] k, input bit scribble,
                          output logic [127:0] ct);
        int lat;
        logic [127:0] exp_ct;
        exp_ct   = ref_encrypt(pt, k);
        datain   = pt;
        key      = k;
        in_valid = 1'b1;
        chk_bit("in_ready_before_accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_bit("busy_after_accept", busy, 1'b1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            out_ready = 1'($urandom_range(0, 1));
            if (scribble) begin
                datain = '1;
                key    = '1;
            end else begin
                datain = {$urandom, $urandom, $urandom, $urandom};
                key    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            tick();
            lat++;
        end
        out_ready = 1'b0;
        #1;
        chk_int("latency", lat, 14);
        chk_bit("busy_in_done", busy, 1'b0);
        chk_bit("in_ready_in_done", in_ready, 1'b0);
        chk_blk("ciphertext", dataout, exp_ct);
        chk_blk("round_trip", ref_decrypt(dataout, k), pt);
        ct = dataout;
        repeat ($urandom_range(0, 2)) tick();
        chk_bit("out_valid_held", out_valid, 1'b1);
        chk_blk("dataout_held", dataout, ct);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_bit("out_valid_after_hs", out_valid, 1'b0);
        chk_blk("dataout_kept_after_hs", dataout, ct);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] ct, pa, pb, exp_a;
        logic [255:0] ka, kb;
        int  lat;
        bit  seen;

        build_sbox();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        datain    = '0;
        key       = '0;
        repeat (3) tick();
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_blk("rst_dataout", dataout, 128'h0);
        rst = 1'b0;
        #1;
        chk_bit("in_ready_after_rst", in_ready, 1'b1);

        do_job(C3_PT, C3_KEY, 1'b0, ct);
        chk_blk("fips_c3", ct, C3_CT);
        do_job(C3_PT, C3_KEY, 1'b1, ct);
        chk_blk("input_isolation", ct, C3_CT);
        do_job(128'h0, 256'h0, 1'b0, ct);
        chk_blk("all_zero", ct, ZERO_CT);

        // Backpressure with a second job waiting throughout.
        pa = {$urandom, $urandom, $urandom, $urandom};
        ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        exp_a     = ref_encrypt(pa, ka);
        datain    = pa;
        key       = ka;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        datain = pb;
        key    = kb;
        wait_result(lat);
        chk_int("bp_latency_a", lat, 14);
        chk_blk("bp_result_a", dataout, exp_a);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_bit("bp_out_valid_stable", out_valid, 1'b1);
            chk_bit("bp_in_ready_low", in_ready, 1'b0);
            chk_blk("bp_dataout_stable", dataout, exp_a);
        end
        out_ready = 1'b1;
        #1;
`ifdef AES256_ENC_BACK2BACK_EN
        chk_bit("b2b_in_ready_follows_out_ready", in_ready, 1'b1);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk_bit("b2b_accept_same_edge", busy, 1'b1);
        chk_bit("b2b_out_valid_drop", out_valid, 1'b0);
`else
        chk_bit("bp_in_ready_during_hs", in_ready, 1'b0);
        tick();
        out_ready = 1'b0;
        chk_bit("bp_idle_out_valid", out_valid, 1'b0);
        chk_bit("bp_idle_busy", busy, 1'b0);
        chk_bit("bp_idle_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_bit("bp_accept_next_cycle", busy, 1'b1);
`endif
        wait_result(lat);
        chk_int("bp_latency_b", lat, 14);
        chk_blk("bp_result_b", dataout, ref_encrypt(pb, kb));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_bit("bp_b_handshake", out_valid, 1'b0);

        // Reset during round 7 aborts the job.
        datain   = C3_PT;
        key      = C3_KEY;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        chk_bit("midrun_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk_bit("midrun_rst_busy", busy, 1'b0);
        chk_bit("midrun_rst_out_valid", out_valid, 1'b0);
        chk_bit("midrun_rst_in_ready", in_ready, 1'b0);
        chk_blk("midrun_rst_dataout", dataout, 128'h0);
        rst = 1'b0;
        #1;
        chk_bit("midrun_in_ready_after_rst", in_ready, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk_bit("midrun_no_out_valid", seen, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            pa = {$urandom, $urandom, $urandom, $urandom};
            ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            do_job(pa, ka, 1'b0, ct);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes256_encipher_seq.md
AES256_ENCIPHER_SEQ -- requirements
Module: aes256_encipher_seq

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 128-bit block and 256-bit key.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  datain/key valid.
REQ-005 in_ready  output  1  block can accept a new job.
REQ-006 datain  input  128  plaintext; datain[127:120] = FIPS-197 byte 0.
REQ-007 key  input  256  cipher key; key[255:248] = key byte 0.
REQ-008 out_valid  output  1  dataout holds a finished ciphertext.
REQ-009 out_ready  input  1  consumer accepts dataout.
REQ-010 dataout  output  128  ciphertext, same byte order as datain.
REQ-011 busy  output  1  high while rounds are in progress.

Function
REQ-012 Output SHALL be AES-256 encryption per FIPS-197: 14 rounds, with round 14 omitting MixColumns; dataout SHALL be the exact inverse of the team's combinational AES-256 decipher for the same key.
REQ-013 FSM states SHALL be IDLE, ROUND and DONE; reset state is IDLE.
REQ-014 in_ready SHALL be 1 in IDLE and 0 in ROUND and DONE (see REQ-028 for the exception).
REQ-015 Accept happens on any edge with in_valid=1 and in_ready=1.
- On accept, the state register SHALL load datain XOR key[255:128].
- On accept, the key window register SHALL load key.
- On accept, the round counter SHALL load 1 and the FSM SHALL go IDLE->ROUND.
REQ-016 datain and key SHALL be sampled only at accept; later changes to them SHALL have no effect on the job in flight.
REQ-017 In ROUND, exactly one round SHALL execute per clock.
- Round 1 uses key window bits [127:0].
- The key schedule SHALL be expanded on the fly, one 128-bit half per round, with Rcon advancing every second round.
- No precomputed key table SHALL be stored.
REQ-018 Latency: accept at edge T means round 14 completes at edge T+14, and out_valid and dataout SHALL be valid after edge T+14.
- This gives 14 cycles from accept to out_valid.
- The FSM goes ROUND->DONE on that edge.
REQ-019 busy SHALL equal (state==ROUND).
REQ-020 In DONE, out_valid=1 and dataout SHALL be held stable until out_ready=1 is sampled; the FSM then goes DONE->IDLE and out_valid=0 on the next cycle.
REQ-021 dataout SHALL keep the last ciphertext after the handshake and SHALL update only at the next round-14 completion.
REQ-022 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored when in_ready=0.
REQ-023 There SHALL be no job overlap: at most one job is held at a time.

Reset
REQ-024 While rst=1 is sampled, the next state SHALL be IDLE, and the round counter, state register, key window and dataout SHALL all be 0.
REQ-025 While rst=1 is sampled, out_valid SHALL be 0 and busy SHALL be 0.
REQ-026 in_ready SHALL be forced to 0 while rst=1 and SHALL be 1 on the first cycle after rst deasserts.
REQ-027 rst asserted in ROUND or DONE SHALL abort the job silently: no out_valid is produced, and the result is discarded.

Configuration
REQ-028 Macro AES256_ENC_BACK2BACK_EN controls back-to-back acceptance.
- Defined: in DONE, in_ready = out_ready. A simultaneous output handshake and input accept on the same edge SHALL go DONE->ROUND directly, with no IDLE cycle. Sustained throughput is one block per 15 cycles.
- Undefined: REQ-014 applies unchanged, and sustained throughput is one block per 16 cycles.

Verification
REQ-029 FIPS-197 C.3 vector: datain=00112233445566778899aabbccddeeff, key=000102...1e1f, out_ready=1 -> out_valid exactly 14 cycles after accept, dataout=8ea2b7ca516745bfeafc49904b496089.
REQ-030 Backpressure and no-overlap: hold out_ready=0 for 20 cycles after out_valid, and hold in_valid=1 with a second job throughout.
- dataout and out_valid SHALL stay stable, and in_ready SHALL stay 0.
- Then pulse out_ready. The second job SHALL be accepted exactly 1 cycle later with the macro undefined, or on the same edge with the macro defined.
REQ-031 Reset mid-run: assert rst at round 7 of the C.3 job -> out_valid SHALL never assert for that job, and in_ready SHALL be 1 on the first cycle after rst drops.
REQ-032 Input isolation: after accept, change datain/key to all-ones every cycle -> result SHALL still be 8ea2b7ca516745bfeafc49904b496089.
REQ-033 Round trip: 1000 random datain/key pairs -> feeding dataout into the team's AES-256 decipher with the same key SHALL return the original datain in every case.
REQ-034 All-zero vector: datain=0, key=0 -> dataout=dc95c078a2408989ad48a21492842087.
